// File: rtl/booth_r8_pkg.sv
// booth_r8_pkg: shared types and constants for the radix-8 Booth sequencer.
// Holds the controller state encoding, the multiple-select encodings and the
// helpers that derive the iteration count and counter width from OP_W.
// The SHIFT state only exists when BOOTH_FUSED_EN is not defined.
package booth_r8_pkg;

    localparam logic [1:0] SEL_M  = 2'b00;
    localparam logic [1:0] SEL_2M = 2'b01;
    localparam logic [1:0] SEL_3M = 2'b10;
    localparam logic [1:0] SEL_4M = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
`ifndef BOOTH_FUSED_EN
        ST_SHIFT = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    // Each recoding group consumes three multiplier bits of the sign-extended operand.
    function automatic int iter_of(input int op_w);
        return (op_w + 1) / 3;
    endfunction

    // The counter has to reach ITER itself, which it holds while in DONE.
    function automatic int cnt_w(input int op_w);
        return $clog2(iter_of(op_w) + 1);
    endfunction

    // The sign-extended operand must split evenly into 3-bit groups.
    function automatic bit op_w_ok(input int op_w);
        return (op_w >= 2) && (((op_w + 1) % 3) == 0);
    endfunction

endpackage

// File: rtl/booth_r8_recode.sv
// booth_r8_recode: radix-8 Booth digit recoder.
// Turns the window {q[2], q[1], q[0], qNeg} into the signed digit
// v = -4*b[3] + 2*b[2] + b[1] + b[0], expressed as a zero flag, a subtract
// flag and the magnitude select for the M/2M/3M/4M multiple mux.
module booth_r8_recode
    import booth_r8_pkg::*;
(
    input  logic [3:0] booth_bits,
    output logic       zero,
    output logic       sub,
    output logic [1:0] mult_sel
);

    // Negative digits always have b[3] set; 0000 and 1111 are the two zero digits and report no subtract.
    always_comb begin
        zero     = 1'b0;
        sub      = booth_bits[3];
        mult_sel = SEL_M;
        case (booth_bits)
            4'b0000, 4'b1111: begin
                zero = 1'b1;
                sub  = 1'b0;
            end
            4'b0001, 4'b0010, 4'b1101, 4'b1110: mult_sel = SEL_M;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: mult_sel = SEL_2M;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: mult_sel = SEL_3M;
            default:                            mult_sel = SEL_4M;
        endcase
    end

endmodule

// File: rtl/booth_r8_seq.sv
// booth_r8_seq: control sequencer for the radix-8 Booth multiplier datapath.
// Accepts a start handshake, loads the operands, walks ITER recoding groups
// issuing add/subtract and shift strobes, then holds a done handshake.
// Optional build macro BOOTH_FUSED_EN: the datapath adds and shifts in the
// same cycle, so every group costs one EVAL cycle and there is no SHIFT state.
module booth_r8_seq
    import booth_r8_pkg::*;
#(
    parameter int OP_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    abort,
    input  logic [3:0]              booth_bits,
    output logic                    ld_op,
    output logic                    ld_a_en,
    output logic [1:0]              mult_sel,
    output logic                    sub,
    output logic                    shift_en,
    output logic [cnt_w(OP_W)-1:0]  cnt,
    output logic                    busy,
    output logic                    done_valid,
    input  logic                    done_ready
);

    localparam int ITER  = iter_of(OP_W);
    localparam int CNT_W = cnt_w(OP_W);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(ITER - 1);

    if (!op_w_ok(OP_W)) begin : g_bad_op_w
        $error("booth_r8_seq: OP_W+1 must be a multiple of 3");
    end

    state_t     state;
    state_t     state_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       last_grp;
    logic       grp_zero;
    logic       grp_sub;
    logic [1:0] grp_sel;

    booth_r8_recode u_recode (
        .booth_bits (booth_bits),
        .zero       (grp_zero),
        .sub        (grp_sub),
        .mult_sel   (grp_sel)
    );

    assign last_grp = (cnt == LAST_GRP);
    assign busy     = (state != ST_IDLE);

    // State register; reset drops straight back to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Group counter: cleared on load or abort, stepped once per completed group.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state and strobe decode; abort wins in every busy state and silences all strobes.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        ld_op       = 1'b0;
        ld_a_en     = 1'b0;
        mult_sel    = SEL_M;
        sub         = 1'b0;
        shift_en    = 1'b0;
        done_valid  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cnt_clr = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ld_op     = 1'b1;
                    state_nxt = ST_EVAL;
                end
            end

            ST_EVAL: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
`ifdef BOOTH_FUSED_EN
                    ld_a_en   = !grp_zero;
                    mult_sel  = grp_zero ? SEL_M : grp_sel;
                    sub       = !grp_zero && grp_sub;
                    shift_en  = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = last_grp ? ST_DONE : ST_EVAL;
`else
                    if (grp_zero) begin
                        shift_en  = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = last_grp ? ST_DONE : ST_EVAL;
                    end else begin
                        ld_a_en   = 1'b1;
                        mult_sel  = grp_sel;
                        sub       = grp_sub;
                        state_nxt = ST_SHIFT;
                    end
`endif
                end
            end

`ifndef BOOTH_FUSED_EN
            ST_SHIFT: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    shift_en  = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = last_grp ? ST_DONE : ST_EVAL;
                end
            end
`endif

            ST_DONE: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    done_valid  = 1'b1;
                    start_ready = done_ready;
                    if (done_ready) begin
                        state_nxt = start_valid ? ST_LOAD : ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_r8_seq.sv
// tb_booth_r8_seq: self-checking bench for booth_r8_seq.
// A behavioural A/Q/qNeg datapath closes the loop around the sequencer, a
// scoreboard pairs each accepted start with its expected product and latency,
// and hand-written sequences cover back-to-back, abort and async reset.
module tb_booth_r8_seq;

    localparam int OP_W = 32;
    localparam int ITER = (OP_W + 1) / 3;
    localparam int CW   = $clog2(ITER + 1);

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic          abort = 1'b0;
    logic [3:0]    booth_bits;
    logic          ld_op;
    logic          ld_a_en;
    logic [1:0]    mult_sel;
    logic          sub;
    logic          shift_en;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done_valid;
    logic          done_ready = 1'b0;

    logic [31:0]   op_x = '0;
    logic [31:0]   op_y = '0;

    int            n_checks = 0;
    int            n_pass = 0;
    longint        cyc = 0;
    logic          done_prev = 1'b0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] prod;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t   sb_q[$];
    longint t_q[$];
    vec_t   vecs[12];

    booth_r8_seq #(.OP_W(OP_W)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .booth_bits  (booth_bits),
        .ld_op       (ld_op),
        .ld_a_en     (ld_a_en),
        .mult_sel    (mult_sel),
        .sub         (sub),
        .shift_en    (shift_en),
        .cnt         (cnt),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: A accumulates the selected multiple, then {A,Q,qNeg} shifts right by 3.
    logic signed [39:0] dp_a = '0;
    logic signed [39:0] dp_m = '0;
    logic [32:0]        dp_q = '0;
    logic               dp_qneg = 1'b0;
    logic signed [39:0] dp_mult;
    logic signed [39:0] dp_a1;
    logic [63:0]        dp_prod;

    always_comb begin
        dp_mult = dp_m;
        case (mult_sel)
            2'b00:   dp_mult = dp_m;
            2'b01:   dp_mult = dp_m <<< 1;
            2'b10:   dp_mult = dp_m + (dp_m <<< 1);
            default: dp_mult = dp_m <<< 2;
        endcase
        dp_a1 = dp_a;
        if (ld_a_en) dp_a1 = sub ? (dp_a - dp_mult) : (dp_a + dp_mult);
    end

    always @(posedge clk) begin
        if (ld_op) begin
            dp_a    <= '0;
            dp_q    <= {op_x[31], op_x};
            dp_qneg <= 1'b0;
            dp_m    <= {{8{op_y[31]}}, op_y};
        end else if (shift_en) begin
            dp_a    <= dp_a1 >>> 3;
            dp_q    <= {dp_a1[2:0], dp_q[32:3]};
            dp_qneg <= dp_q[2];
        end else begin
            dp_a    <= dp_a1;
        end
    end

    assign booth_bits = {dp_q[2:0], dp_qneg};
    assign dp_prod    = {dp_a[30:0], dp_q};

    // Independent digit value of the current window.
    int exp_v;
    int exp_abs;
    always_comb begin
        exp_v   = -4 * int'(booth_bits[3]) + 2 * int'(booth_bits[2])
                  + int'(booth_bits[1]) + int'(booth_bits[0]);
        exp_abs = (exp_v < 0) ? -exp_v : exp_v;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic int exp_lat(input logic [31:0] x);
        logic [32:0] xe;
        logic        prev;
        logic [3:0]  g;
        int          nz;
        xe   = {x[31], x};
        prev = 1'b0;
        nz   = 0;
        for (int i = 0; i < ITER; i++) begin
            g = {xe[3*i+2 -: 3], prev};
            if (g != 4'b0000 && g != 4'b1111) nz++;
            prev = xe[3*i+2];
        end
`ifdef BOOTH_FUSED_EN
        return 2 + ITER;
`else
        return 2 + ITER + nz;
`endif
    endfunction

    function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input int hold);
        vec_t v;
        v.x    = x;
        v.y    = y;
        v.prod = ref_mul(x, y);
        v.lat  = exp_lat(x);
        v.hold = hold;
        return v;
    endfunction

    // Output monitor: recoding strobes every busy cycle, scoreboard pop on each new done.
    always @(negedge clk) begin
        if (!rst_b) begin
            done_prev <= 1'b0;
        end else begin
            done_prev <= done_valid;
            if (start_valid && start_ready) t_q.push_back(cyc);
            if (busy && !done_valid) checkOutput("start_ready_busy", start_ready, 0);
            if (ld_a_en) begin
                checkOutput("recode_nonzero", exp_v != 0, 1);
                checkOutput("recode_sel", mult_sel, exp_abs - 1);
                checkOutput("recode_sub", sub, exp_v < 0);
`ifndef BOOTH_FUSED_EN
                checkOutput("add_without_shift", shift_en, 0);
`endif
            end else if (busy) begin
                checkOutput("sel_gated", mult_sel, 0);
                checkOutput("sub_gated", sub, 0);
            end
            if (done_valid && !done_prev) begin
                if (sb_q.size() == 0 || t_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    checkOutput("product", dp_prod, sb_q[0].prod);
                    checkOutput("latency", cyc - t_q[0], sb_q[0].lat);
                    checkOutput("cnt_at_done", cnt, ITER);
                    sb_q.delete(0);
                    t_q.delete(0);
                end
            end
        end
    end

    task automatic recover();
        rst_b = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        abort = 1'b0;
        sb_q.delete();
        t_q.delete();
        @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic startOp(input vec_t v);
        checkOutput("start_ready_idle", start_ready, 1);
        op_x = v.x;
        op_y = v.y;
        sb_q.push_back('{prod: v.prod, lat: v.lat});
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic waitDone(output bit got);
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (done_valid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checkOutput("done_timeout", 0, 1);
            recover();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bit got;
        startOp(v);
        waitDone(got);
        if (got) begin
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput("done_hold", done_valid, 1);
                checkOutput("start_ready_wait", start_ready, 0);
            end
            done_ready = 1'b1;
            #1 checkOutput("start_ready_done", start_ready, 1);
            @(posedge clk);
            #1 done_ready = 1'b0;
            checkOutput("idle_after_done", busy, 0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit got;
        bit found;

        vecs[0]  = mk(32'd2, 32'd3, 1);
        vecs[1]  = mk(32'hFFFF_FFFF, 32'd5, 0);
        vecs[2]  = mk(32'h5B6D_B6DB, 32'h0001_2345, 0);
        vecs[3]  = mk(32'h5B6D_B6DB, 32'hFFFF_FFF9, 2);
        vecs[4]  = mk(32'hA492_4924, 32'h7FFF_FFFF, 0);
        vecs[5]  = mk(32'h8000_0000, 32'h8000_0000, 0);
        vecs[6]  = mk(32'h7FFF_FFFF, 32'h8000_0000, 0);
        vecs[7]  = mk(32'h0000_0000, 32'h0000_DEAD, 0);
        vecs[8]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        vecs[9]  = mk(32'h5B6D_B6DB, 32'h5B6D_B6DB, 0);
        vecs[10] = mk($urandom, $urandom, 0);
        vecs[11] = mk($urandom, $urandom, 1);

        #3;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cnt", cnt, 0);
        checkOutput("reset_start_ready", start_ready, 1);
        checkOutput("reset_done_valid", done_valid, 0);
        checkOutput("reset_strobes", {ld_op, ld_a_en, shift_en, sub, mult_sel}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b1;
        checkOutput("post_reset_idle", {busy, start_ready}, 2'b01);

        // abort in IDLE has no effect
        abort = 1'b1;
        #1 checkOutput("abort_idle_ready", start_ready, 1);
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abort_idle_busy", busy, 0);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // back-to-back: release done and request the next product in the same cycle
        startOp(vecs[2]);
        waitDone(got);
        if (got) begin
            op_x = vecs[1].x;
            op_y = vecs[1].y;
            sb_q.push_back('{prod: vecs[1].prod, lat: vecs[1].lat});
            start_valid = 1'b1;
            done_ready  = 1'b1;
            #1 checkOutput("b2b_start_ready", start_ready, 1);
            @(posedge clk);
            #1 start_valid = 1'b0;
            done_ready = 1'b0;
            checkOutput("b2b_load", ld_op, 1);
            checkOutput("b2b_no_idle", busy, 1);
            @(posedge clk);
            #1 checkOutput("b2b_cnt_restart", cnt, 0);
            waitDone(got);
            if (got) begin
                done_ready = 1'b1;
                @(posedge clk);
                #1 done_ready = 1'b0;
            end
        end

        // abort while evaluating group 5
        startOp(vecs[0]);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (busy && cnt == 5) found = 1'b1;
        end
        checkOutput("abort_reach_cnt5", found, 1);
        abort = 1'b1;
        #1;
        checkOutput("abort_strobes", {ld_op, ld_a_en, shift_en}, 0);
        checkOutput("abort_done_gated", done_valid, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        sb_q.delete();
        t_q.delete();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cnt", cnt, 0);
        checkOutput("abort_start_ready", start_ready, 1);
        applyStimulus(vecs[1]);

        // asynchronous reset in the shift cycle of group 0
        startOp(vecs[0]);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (shift_en && cnt == 0) found = 1'b1;
        end
        checkOutput("reset_reach_shift", found, 1);
        #1 rst_b = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_cnt", cnt, 0);
        checkOutput("async_start_ready", start_ready, 1);
        checkOutput("async_strobes", {ld_op, ld_a_en, shift_en, sub, mult_sel}, 0);
        checkOutput("async_done_valid", done_valid, 0);
        sb_q.delete();
        t_q.delete();
        @(posedge clk);
        #1 rst_b = 1'b1;
        applyStimulus(vecs[3]);

        @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
